// File: rtl/tally_pkg.sv
// Shared types and constants for the round tally: FSM states, settle threshold,
// seven-segment patterns and a two-digit BCD increment helper.
package tally_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } tally_state_e;

    localparam logic [1:0] SETTLE_THRESHOLD = 2'd3;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/digit7seg.sv
// One BCD digit to an active-low seven-segment pattern; non-decimal codes blank.
module digit7seg
    import tally_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/round_tally.sv
// Debounces the game's win lights into committed rounds and keeps BCD win/tie
// counts, a round count and a win streak, with seven-segment display decode.
module round_tally
    import tally_pkg::*;
(
    input  logic         fast_clock,
    input  logic         resetb,
    input  logic         player_win_light,
    input  logic         dealer_win_light,
    input  logic         clear,
    output logic [7:0]   pwins,
    output logic [7:0]   dwins,
    output logic [7:0]   ties,
    output logic [7:0]   rounds,
    output logic [3:0]   streak,
    output logic         streak_dealer,
    output logic         result_valid,
    output logic [6:0]   HEX5,
    output logic [6:0]   HEX4,
    output logic [6:0]   HEX3,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX0,
    output tally_state_e state_dbg
);

    // Light pairs are {player, dealer}: 10 player, 01 dealer, 11 tie.
    logic [1:0]   lights_meta;
    logic [1:0]   lights_sync;
    logic [1:0]   cap, cap_next;
    logic [1:0]   cnt, cnt_next;
    logic         commit;
    tally_state_e state, state_next;

    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            lights_meta <= 2'b00;
            lights_sync <= 2'b00;
            state       <= ST_IDLE;
            cap         <= 2'b00;
            cnt         <= 2'd0;
        end else begin
            lights_meta <= {player_win_light, dealer_win_light};
            lights_sync <= lights_meta;
            state       <= state_next;
            cap         <= cap_next;
            cnt         <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_next   = cap;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lights_sync != 2'b00) begin
                    cap_next   = lights_sync;
                    cnt_next   = 2'd0;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (lights_sync == 2'b00) begin
                    state_next = ST_IDLE;
                end else if (lights_sync != cap) begin
                    cap_next = lights_sync;
                    cnt_next = 2'd0;
                end else begin
                    cnt_next = cnt + 2'd1;
                    if (cnt_next == SETTLE_THRESHOLD) begin
                        commit     = 1'b1;
                        state_next = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (lights_sync == 2'b00) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A win extends the streak when the owner repeats; the other side restarts it at 1.
    always_ff @(posedge fast_clock or negedge resetb) begin
        if (!resetb) begin
            pwins         <= 8'h00;
            dwins         <= 8'h00;
            ties          <= 8'h00;
            rounds        <= 8'd0;
            streak        <= 4'd0;
            streak_dealer <= 1'b0;
        end else if (clear) begin
            pwins         <= 8'h00;
            dwins         <= 8'h00;
            ties          <= 8'h00;
            rounds        <= 8'd0;
            streak        <= 4'd0;
            streak_dealer <= 1'b0;
        end else if (commit) begin
            rounds <= (rounds == 8'd255) ? 8'd255 : rounds + 8'd1;
            case (cap)
                2'b10: begin
                    pwins <= bcd_inc(pwins);
                    if (!streak_dealer) begin
                        streak <= (streak == 4'd15) ? 4'd15 : streak + 4'd1;
                    end else begin
                        streak        <= 4'd1;
                        streak_dealer <= 1'b0;
                    end
                end
                2'b01: begin
                    dwins <= bcd_inc(dwins);
                    if (streak_dealer) begin
                        streak <= (streak == 4'd15) ? 4'd15 : streak + 4'd1;
                    end else begin
                        streak        <= 4'd1;
                        streak_dealer <= 1'b1;
                    end
                end
                default: begin
                    ties   <= bcd_inc(ties);
                    streak <= 4'd0;
                end
            endcase
        end
    end

    assign result_valid = (state == ST_RESULT);
    assign state_dbg    = state;

    digit7seg u_hex5 (.bcd(pwins[7:4]), .seg(HEX5));
    digit7seg u_hex4 (.bcd(pwins[3:0]), .seg(HEX4));
    digit7seg u_hex3 (.bcd(dwins[7:4]), .seg(HEX3));
    digit7seg u_hex2 (.bcd(dwins[3:0]), .seg(HEX2));
    digit7seg u_hex1 (.bcd(ties[7:4]),  .seg(HEX1));
    digit7seg u_hex0 (.bcd(ties[3:0]),  .seg(HEX0));

endmodule

// File: tb/tb_round_tally.sv
// Bench for round_tally: directed vector table, hand sequences for latency,
// clear and reset corners, and random light bursts against a round-level model.
module tb_round_tally;
    import tally_pkg::*;

    logic         fast_clock = 1'b0;
    logic         resetb = 1'b0;
    logic         player_win_light = 1'b0;
    logic         dealer_win_light = 1'b0;
    logic         clear = 1'b0;
    logic [7:0]   pwins, dwins, ties, rounds;
    logic [3:0]   streak;
    logic         streak_dealer, result_valid;
    logic [6:0]   HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    tally_state_e state_dbg;

    round_tally dut (
        .fast_clock(fast_clock), .resetb(resetb),
        .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
        .clear(clear), .pwins(pwins), .dwins(dwins), .ties(ties), .rounds(rounds),
        .streak(streak), .streak_dealer(streak_dealer), .result_valid(result_valid),
        .HEX5(HEX5), .HEX4(HEX4), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0),
        .state_dbg(state_dbg)
    );

    always #10 fast_clock = ~fast_clock;

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    // Round-level model: counts as plain integers, streak by owner.
    int m_p, m_d, m_t, m_r, m_s;
    logic m_sd;

    typedef struct {
        logic [1:0] lights;
        int         hold;
        int         p, d, t, r, s;
        logic       sd;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fast_clock);
            #1;
        end
    endtask

    task automatic set_lights(input logic [1:0] v);
        player_win_light = v[1];
        dealer_win_light = v[0];
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) % 10) * 16 + (n % 10));
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] hex_of(input int p, input int d, input int t);
        logic [7:0] bp, bd, bt;
        bp = to_bcd(p);
        bd = to_bcd(d);
        bt = to_bcd(t);
        return {seg_of(bp[7:4]), seg_of(bp[3:0]), seg_of(bd[7:4]), seg_of(bd[3:0]),
                seg_of(bt[7:4]), seg_of(bt[3:0])};
    endfunction

    task automatic check_counts(input string tag, input int p, input int d, input int t,
                                input int r, input int s, input logic sd);
        check({tag, "_pwins"}, 64'(pwins), 64'(to_bcd(p)));
        check({tag, "_dwins"}, 64'(dwins), 64'(to_bcd(d)));
        check({tag, "_ties"}, 64'(ties), 64'(to_bcd(t)));
        check({tag, "_rounds"}, 64'(rounds), 64'(r));
        check({tag, "_streak"}, 64'({streak, streak_dealer}), 64'({4'(s), sd}));
        check({tag, "_hex"}, 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(hex_of(p, d, t)));
    endtask

    task automatic model_commit(input logic [1:0] v);
        m_r = (m_r >= 255) ? 255 : m_r + 1;
        if (v == 2'b11) begin
            m_t = (m_t + 1) % 100;
            m_s = 0;
        end else begin
            if (v == 2'b10) m_p = (m_p + 1) % 100;
            else            m_d = (m_d + 1) % 100;
            if (m_sd == (v == 2'b01)) begin
                m_s = (m_s >= 15) ? 15 : m_s + 1;
            end else begin
                m_s  = 1;
                m_sd = (v == 2'b01);
            end
        end
    endtask

    task automatic win_round(input logic [1:0] v);
        set_lights(v);
        tick(5);
        set_lights(2'b00);
        tick(4);
    endtask

    initial begin
        vecs[0] = '{2'b10, 2, 1, 0, 0, 1, 1, 1'b0};
        vecs[1] = '{2'b10, 5, 2, 0, 0, 2, 2, 1'b0};
        vecs[2] = '{2'b11, 4, 2, 0, 1, 3, 0, 1'b0};
        vecs[3] = '{2'b01, 4, 2, 1, 1, 4, 1, 1'b1};
        vecs[4] = '{2'b01, 3, 2, 1, 1, 4, 1, 1'b1};
        vecs[5] = '{2'b01, 8, 2, 2, 1, 5, 2, 1'b1};
        vecs[6] = '{2'b10, 4, 3, 2, 1, 6, 1, 1'b0};
        vecs[7] = '{2'b11, 9, 3, 2, 2, 7, 0, 1'b0};
        vecs[8] = '{2'b10, 1, 3, 2, 2, 7, 0, 1'b0};
        vecs[9] = '{2'b11, 3, 3, 2, 2, 7, 0, 1'b0};

        // Reset state
        #5;
        check_counts("reset", 0, 0, 0, 0, 0, 1'b0);
        check("reset_valid_state", 64'({result_valid, state_dbg}), 64'({1'b0, ST_IDLE}));
        tick(2);
        resetb = 1'b1;
        tick(1);

        // Exact latency: counters change on the 6th edge after the input change.
        set_lights(2'b10);
        tick(5);
        check("latency_edge5_pwins", 64'(pwins), 64'h00);
        tick(1);
        check_counts("latency_edge6", 1, 0, 0, 1, 1, 1'b0);
        check("latency_hex4", 64'(HEX4), 64'(7'b1111001));
        check("latency_valid", 64'(result_valid), 64'd1);
        set_lights(2'b00);
        tick(4);

        for (int i = 0; i < 10; i++) begin
            set_lights(vecs[i].lights);
            tick(vecs[i].hold);
            set_lights(2'b00);
            tick(4);
            check_counts($sformatf("vec%0d", i), vecs[i].p, vecs[i].d, vecs[i].t,
                         vecs[i].r, vecs[i].s, vecs[i].sd);
            check($sformatf("vec%0d_idle", i), 64'(state_dbg), 64'(ST_IDLE));
        end

        // Long hold commits once; result_valid drops on the 3rd edge after release.
        set_lights(2'b01);
        tick(20);
        check_counts("hold20", 3, 3, 2, 8, 1, 1'b1);
        check("hold20_valid", 64'(result_valid), 64'd1);
        set_lights(2'b00);
        tick(2);
        check("release_edge2_valid", 64'(result_valid), 64'd1);
        tick(1);
        check("release_edge3_valid", 64'(result_valid), 64'd0);

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_counts("clear", 0, 0, 0, 0, 0, 1'b0);

        // Clear on the commit edge wins, FSM still advances to RESULT.
        set_lights(2'b10);
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_counts("clear_on_commit", 0, 0, 0, 0, 0, 1'b0);
        check("clear_on_commit_state", 64'(state_dbg), 64'(ST_RESULT));
        set_lights(2'b00);
        tick(4);

        // Reset during SETTLE discards the pending round.
        win_round(2'b01);
        set_lights(2'b10);
        tick(4);
        check("mid_settle_state", 64'(state_dbg), 64'(ST_SETTLE));
        resetb = 1'b0;
        #2;
        check("mid_reset_state", 64'(state_dbg), 64'(ST_IDLE));
        set_lights(2'b00);
        tick(2);
        resetb = 1'b1;
        tick(8);
        check_counts("mid_reset", 0, 0, 0, 0, 0, 1'b0);

        // Random bursts of light segments; first segment held >= 4 cycles commits.
        m_p = 0; m_d = 0; m_t = 0; m_r = 0; m_s = 0; m_sd = 1'b0;
        for (int b = 0; b < 40; b++) begin
            int nseg;
            bit committed;
            logic [1:0] prev, v;
            int h;
            nseg = $urandom_range(1, 3);
            committed = 1'b0;
            prev = 2'b00;
            for (int s = 0; s < nseg; s++) begin
                v = 2'($urandom_range(1, 3));
                if (v == prev) v = 2'((v % 3) + 1);
                h = $urandom_range(1, 7);
                set_lights(v);
                tick(h);
                if (!committed && h >= 4) begin
                    model_commit(v);
                    committed = 1'b1;
                end
                prev = v;
            end
            set_lights(2'b00);
            tick($urandom_range(3, 5));
            exp_q.push_back({to_bcd(m_p), to_bcd(m_d), to_bcd(m_t), 8'(m_r), 4'(m_s), m_sd});
            check($sformatf("rand%0d_counts", b),
                  64'({pwins, dwins, ties, rounds, streak, streak_dealer}), 64'(exp_q.pop_front()));
            check($sformatf("rand%0d_idle", b), 64'(state_dbg), 64'(ST_IDLE));
        end

        // BCD wrap at 99 and saturation of streak and rounds.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        for (int i = 0; i < 99; i++) win_round(2'b10);
        check("preload99_pwins", 64'(pwins), 64'h99);
        win_round(2'b10);
        check_counts("wrap100", 0, 0, 0, 100, 15, 1'b0);
        for (int i = 0; i < 155; i++) win_round(2'b01);
        check_counts("rounds255", 0, 55, 0, 255, 15, 1'b1);
        win_round(2'b01);
        check_counts("rounds_sat", 0, 56, 0, 255, 15, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/round_tally.md
ROUND_TALLY -- requirements
Module: round_tally

Interface
REQ-001 SHALL have port fast_clock, input, 1, sole clock (50 MHz); all state changes on its rising edge.
REQ-002 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port player_win_light, input, 1, player result from the game state machine; asynchronous to fast_clock.
REQ-004 SHALL have port dealer_win_light, input, 1, dealer result; both inputs high means tie.
REQ-005 SHALL have port clear, input, 1, synchronous active-high tally clear.
REQ-006 SHALL have ports pwins, dwins, ties, output, 8 each, two-digit BCD counts ({tens,units}).
REQ-007 SHALL have port rounds, output, 8, binary count of committed rounds.
REQ-008 SHALL have port streak, output, 4, count of consecutive wins by one side.
REQ-009 SHALL have port streak_dealer, output, 1, owner of the current streak: 1 dealer, 0 player.
REQ-010 SHALL have port result_valid, output, 1, high while FSM is in RESULT.
REQ-011 SHALL have ports HEX5..HEX0, output, 7 each, active-low segments {g..a}: HEX5/4 pwins, HEX3/2 dwins, HEX1/0 ties, tens digit on the higher index.

Function
REQ-012 SHALL synchronize both light inputs through two flops each before any use.
REQ-013 SHALL implement FSM states IDLE, SETTLE, RESULT.
REQ-014 IDLE: on synchronized lights != 00, SHALL capture value, zero settle counter, go SETTLE.
REQ-015 SETTLE: synchronized lights equal capture SHALL increment settle counter; on the edge it reaches 3, SHALL commit and go RESULT.
REQ-016 SETTLE: lights differ and nonzero SHALL recapture and zero the counter; lights 00 SHALL return to IDLE without commit.
REQ-017 RESULT: synchronized lights 00 SHALL return to IDLE; any nonzero value SHALL hold RESULT (no second commit).
REQ-018 Commit for 10 SHALL increment pwins, 01 dwins, 11 ties; every commit SHALL increment rounds.
REQ-019 Input change held stable SHALL be reflected on counters after exactly the 6th rising edge following the change.
REQ-020 BCD counters SHALL count 00..99, wrapping 99 -> 00; units 9 SHALL carry into tens.
REQ-021 rounds SHALL saturate at 255.
REQ-022 Win by the same side as streak owner SHALL increment streak, saturating at 15; win by other side SHALL set streak 1 and flip owner; tie SHALL set streak 0, owner unchanged.
REQ-023 clear SHALL zero pwins, dwins, ties, rounds, streak, streak_dealer; FSM state unaffected.
REQ-024 clear coinciding with a commit SHALL win: all counts 0 after that edge.
REQ-025 HEX outputs SHALL be combinational decode of counters: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; other codes blank 1111111.

Reset
REQ-026 resetb low SHALL immediately force FSM IDLE, sync flops 0, settle counter 0, all counters 0, streak_dealer 0, result_valid 0.
REQ-027 After reset, all HEX outputs SHALL show 1000000.
REQ-028 Reset mid-SETTLE SHALL discard the pending round; no commit.

Structure
REQ-029 Shared package tally_pkg SHALL hold the FSM state enum, settle threshold constant (3), and segment pattern constants.
REQ-030 A sub-module digit7seg (4-bit BCD in, 7-bit active-low out) SHALL be instantiated six times.

Verification
REQ-031 Reset, drive lights 10 stable -> pwins=0x01, rounds=1, streak=1, streak_dealer=0, HEX4=1111001 on edge 6.
REQ-032 Lights 10 for 2 cycles then 00 -> no counter change; FSM back in IDLE.
REQ-033 Lights 11 after two player wins -> ties=0x01, streak=0, streak_dealer=0, rounds=3.
REQ-034 Preload 99 player wins, one more -> pwins=0x00, HEX5=HEX4=1000000.
REQ-035 Lights 01 held 20 cycles -> single commit, dwins=0x01, result_valid high until lights 00.
REQ-036 clear asserted on the commit edge -> all counters 0; resetb pulsed low mid-SETTLE -> no commit.
